uart_cmd_packer: RTL and testbench
==================================

Name: uart_cmd_packer

Overview:
- Host-side initiator for the diff_freq_serial_out UART command protocol.
- Accepts one abstract command per handshake (opcode, channel, 32-bit word) and serializes it into the exact byte sequence the receiver-side decoder expects.
- Drives the UART TX interface: tx_start / tx_data, with tx_done_tick as the per-byte acknowledge.
- Sits between a register/CPU front end and the UART core.

Parameters:
- PACK_NUM, 4, number of data-pattern bytes in a DATA command; legal range 1..4.
- CHAN_W, 8, channel field width; always sent as one byte, zero-extended.
- ECHO_TIMEOUT, 20000, clock cycles to wait for the echoed byte (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
- cmd_type_i  in  3  0=DATA 1=CTRL 2=FREQ 3=PERIOD 4=REPEAT 5=GLOBAL; others illegal
- cmd_chan_i  in  CHAN_W  channel number
- cmd_word_i  in  32  payload; field use depends on type
- tx_start_o  out  1  single-cycle request to the UART TX
- tx_data_o  out  8  byte to transmit
- tx_done_tick_i  in  1  UART TX byte-complete pulse
- cmd_done_o  out  1  one-cycle pulse when the last byte of a command completes
- cmd_err_o  out  1  one-cycle pulse on an illegal type (and on echo errors, see Optional Feature)
- busy_o  out  1  high from acceptance until cmd_done_o or cmd_err_o

Behaviour:
- Reset values: cmd_ready_o=1; tx_start_o, tx_data_o, cmd_done_o, cmd_err_o and busy_o all 0. Reset mid-command aborts immediately. No partial-resume; the UART byte already in flight is abandoned.
- Byte sequences: words are sent LSB byte first.
  - DATA: CMD_DATA, chan, word[7:0] .. up to PACK_NUM bytes; length 2+PACK_NUM.
  - CTRL: CMD_CTRL, chan, {4'h0, word[3], word[2:1], word[0]} = {idle, mode, en}; length 3.
  - FREQ: CMD_FREQ, word bytes 0..3; length 5.
  - PERIOD: CMD_PERIOD, word[7:0] (slow), word[15:8] (fast); length 3.
  - REPEAT: CMD_REPEAT, chan, word[7:0]; length 3.
  - GLOBAL: CMD_GLOBAL, {7'h0, word[0]}; length 2.
- FSM states:
  - IDLE -> LOAD on handshake. Type, chan, word and byte count are latched, so inputs may change afterwards.
  - LOAD -> SEND: tx_data_o is set to byte[idx].
  - SEND: assert tx_start_o for exactly 1 cycle -> WAIT.
  - WAIT: on tx_done_tick_i, if idx==len-1 go to FIN, else idx++ and go to LOAD.
  - FIN: pulse cmd_done_o, then go to IDLE.
- Illegal type: accepted; cmd_err_o pulses the next cycle; no bytes are sent; return to IDLE.
- tx_data_o is held stable from tx_start_o until the matching tx_done_tick_i.
- cmd_ready_o=1 only in IDLE. The next command can be accepted the cycle after cmd_done_o.
- tx_done_tick_i outside WAIT is ignored. A tick arriving in the same cycle as tx_start_o is not counted.
- Latency: accept at cycle 0; tx_start_o at cycle 2; each following byte starts 2 cycles after the previous done tick.

Optional Feature:
- Macro: UART_CMD_ECHO_CHECK_EN.
- When defined:
  - Adds inputs rx_done_tick_i (1 bit) and rx_data_i (8 bits); the loopback receiver echoes every byte.
  - After each tx_done_tick_i the FSM enters WAIT_ECHO.
  - A matching rx_data_i on rx_done_tick_i advances the sequence.
  - A mismatch, or ECHO_TIMEOUT cycles without an echo, pulses cmd_err_o, aborts the remaining bytes and returns to IDLE.
- When undefined: these ports and the WAIT_ECHO state do not exist; behaviour is exactly as above.

Decomposition:
- Shared header user_cmd.vh: CMD_DATA, CMD_CTRL, CMD_FREQ, CMD_PERIOD, CMD_REPEAT, CMD_GLOBAL byte codes; the cmd_type encodings; the CTRL bit positions (en, mode, idle).
- Single module. No sub-module: the byte-select mux is a combinational function inside the module.

Test Plan:
- FREQ, word=32'h5555_5555, UART modelled with 10-cycle tx_done -> bytes CMD_FREQ,55,55,55,55; exactly 5 tx_start_o pulses; cmd_done_o once.
- PERIOD, word=16'h0514 -> bytes CMD_PERIOD,14,05. REPEAT chan=15, word=3 -> bytes CMD_REPEAT,0F,03.
- CTRL chan=13, idle=1, mode=00, en=1 -> bytes CMD_CTRL,0D,09. GLOBAL word=1 -> bytes CMD_GLOBAL,01.
- cmd_type=7 -> no tx_start_o; cmd_err_o pulses once; cmd_ready_o returns to 1. Also: cmd_valid_i held high while busy -> the second command starts only after cmd_done_o; cmd_word_i changed mid-send -> no effect on bytes in flight.
- Assert rst_n during byte 3 of a DATA command -> all outputs return to reset values immediately; a fresh command afterwards sends a full 6-byte sequence.
- With UART_CMD_ECHO_CHECK_EN: loopback echo corrupted on byte 2 -> cmd_err_o, remaining bytes not sent. Echo suppressed -> cmd_err_o exactly ECHO_TIMEOUT cycles after the done tick.

Source files
------------

// File: rtl/uart_cmd_packer_pkg.sv
// Shared command encodings for the diff_freq_serial_out UART protocol:
// per-command byte codes, the cmd_type encoding and the CTRL bit layout.
package uart_cmd_packer_pkg;

  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_CTRL   = 8'h02;
  localparam logic [7:0] CMD_FREQ   = 8'h03;
  localparam logic [7:0] CMD_PERIOD = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;
  localparam logic [7:0] CMD_GLOBAL = 8'h06;

  typedef enum logic [2:0] {
    TYPE_DATA   = 3'd0,
    TYPE_CTRL   = 3'd1,
    TYPE_FREQ   = 3'd2,
    TYPE_PERIOD = 3'd3,
    TYPE_REPEAT = 3'd4,
    TYPE_GLOBAL = 3'd5
  } cmd_type_e;

  // CTRL payload byte is {4'h0, idle, mode[1:0], en}, taken from word[3:0]
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IDLE_BIT = 3;

  function automatic logic type_legal(input logic [2:0] t);
    return t <= TYPE_GLOBAL;
  endfunction

endpackage

// File: rtl/uart_cmd_packer.sv
// Serializes one abstract command into its UART byte sequence, one byte per tx_done_tick.
// Optional loopback echo checking is enabled by defining UART_CMD_ECHO_CHECK_EN.
module uart_cmd_packer
  import uart_cmd_packer_pkg::*;
#(
  parameter int PACK_NUM = 4,
  parameter int CHAN_W   = 8
`ifdef UART_CMD_ECHO_CHECK_EN
  ,
  parameter int ECHO_TIMEOUT = 20000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_type_i,
  input  logic [CHAN_W-1:0] cmd_chan_i,
  input  logic [31:0]       cmd_word_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_tick_i,
`ifdef UART_CMD_ECHO_CHECK_EN
  input  logic              rx_done_tick_i,
  input  logic [7:0]        rx_data_i,
`endif
  output logic              cmd_done_o,
  output logic              cmd_err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
`ifdef UART_CMD_ECHO_CHECK_EN
    S_WAIT_ECHO,
`endif
    S_FIN
  } state_e;

  state_e      state;
  cmd_type_e   type_q;
  logic [7:0]  chan_q;
  logic [31:0] word_q;
  logic [2:0]  idx;
  logic [2:0]  last_q;

`ifdef UART_CMD_ECHO_CHECK_EN
  localparam int TMR_W = $clog2(ECHO_TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
`endif

  function automatic logic [2:0] last_idx(input cmd_type_e t);
    case (t)
      TYPE_DATA:   return 3'(PACK_NUM + 1);
      TYPE_CTRL:   return 3'd2;
      TYPE_FREQ:   return 3'd4;
      TYPE_PERIOD: return 3'd2;
      TYPE_REPEAT: return 3'd2;
      TYPE_GLOBAL: return 3'd1;
      default:     return 3'd0;
    endcase
  endfunction

  // Byte-select mux: byte idx of the command currently latched
  function automatic logic [7:0] byte_sel(input cmd_type_e t, input logic [7:0] chan,
                                          input logic [31:0] word, input logic [2:0] i);
    logic [7:0] b;
    logic [1:0] k;
    b = 8'h00;
    k = 2'd0;
    case (t)
      TYPE_DATA: begin
        k = 2'(i - 3'd2);
        if (i == 3'd0)      b = CMD_DATA;
        else if (i == 3'd1) b = chan;
        else                b = word[8*k +: 8];
      end
      TYPE_CTRL: begin
        if (i == 3'd0)      b = CMD_CTRL;
        else if (i == 3'd1) b = chan;
        else b = {4'h0, word[CTRL_IDLE_BIT], word[CTRL_MODE_MSB:CTRL_MODE_LSB], word[CTRL_EN_BIT]};
      end
      TYPE_FREQ: begin
        k = 2'(i - 3'd1);
        if (i == 3'd0) b = CMD_FREQ;
        else           b = word[8*k +: 8];
      end
      TYPE_PERIOD: begin
        if (i == 3'd0)      b = CMD_PERIOD;
        else if (i == 3'd1) b = word[7:0];
        else                b = word[15:8];
      end
      TYPE_REPEAT: begin
        if (i == 3'd0)      b = CMD_REPEAT;
        else if (i == 3'd1) b = chan;
        else                b = word[7:0];
      end
      TYPE_GLOBAL: begin
        if (i == 3'd0) b = CMD_GLOBAL;
        else           b = {7'h0, word[0]};
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // NOTE: rst_n is asserted high here (legacy naming) and acts asynchronously,
  // so a reset mid-command drops the outputs without waiting for a clock edge.
  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= S_IDLE;
      type_q      <= TYPE_DATA;
      chan_q      <= 8'h00;
      word_q      <= 32'h0;
      idx         <= 3'd0;
      last_q      <= 3'd0;
      cmd_ready_o <= 1'b1;
      tx_start_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      cmd_done_o  <= 1'b0;
      cmd_err_o   <= 1'b0;
      busy_o      <= 1'b0;
`ifdef UART_CMD_ECHO_CHECK_EN
      timer       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (!type_legal(cmd_type_i)) begin
              cmd_err_o <= 1'b1;
              state     <= S_FIN;
            end else begin
              type_q <= cmd_type_e'(cmd_type_i);
              chan_q <= 8'(cmd_chan_i);
              word_q <= cmd_word_i;
              last_q <= last_idx(cmd_type_e'(cmd_type_i));
              idx    <= 3'd0;
              state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // tx_start_o rises together with the new byte so the UART samples both at once
          tx_data_o  <= byte_sel(type_q, chan_q, word_q, idx);
          tx_start_o <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          tx_start_o <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_tick_i) begin
`ifdef UART_CMD_ECHO_CHECK_EN
            timer <= TMR_W'(1);
            state <= S_WAIT_ECHO;
`else
            if (idx == last_q) begin
              cmd_done_o <= 1'b1;
              state      <= S_FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
`endif
          end
        end
`ifdef UART_CMD_ECHO_CHECK_EN
        S_WAIT_ECHO: begin
          if (rx_done_tick_i) begin
            if (rx_data_i != tx_data_o) begin
              cmd_err_o <= 1'b1;
              state     <= S_FIN;
            end else if (idx == last_q) begin
              cmd_done_o <= 1'b1;
              state      <= S_FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
          end else if (timer == TMR_W'(ECHO_TIMEOUT - 1)) begin
            cmd_err_o <= 1'b1;
            state     <= S_FIN;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
`endif
        S_FIN: begin
          cmd_done_o  <= 1'b0;
          cmd_err_o   <= 1'b0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_packer.sv
// Scoreboard bench for uart_cmd_packer with a 10-cycle UART TX model;
// echo-check scenarios are included when UART_CMD_ECHO_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_uart_cmd_packer;
  import uart_cmd_packer_pkg::*;

  localparam int PACK_NUM = 4;
  localparam int CHAN_W   = 8;
  localparam int UART_CYC = 10;
`ifdef UART_CMD_ECHO_CHECK_EN
  localparam int ECHO_TIMEOUT = 20000;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [2:0]        cmd_type_i = 3'd0;
  logic [CHAN_W-1:0] cmd_chan_i = '0;
  logic [31:0]       cmd_word_i = 32'h0;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_done_tick_i = 1'b0;
  logic              cmd_done_o;
  logic              cmd_err_o;
  logic              busy_o;
`ifdef UART_CMD_ECHO_CHECK_EN
  logic              rx_done_tick_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  bit                echo_pend = 1'b0;
  bit                echo_mute = 1'b0;
  int                corrupt_no = 0;
`endif

  always #5 clk = ~clk;

  uart_cmd_packer #(
    .PACK_NUM(PACK_NUM),
    .CHAN_W(CHAN_W)
`ifdef UART_CMD_ECHO_CHECK_EN
    ,
    .ECHO_TIMEOUT(ECHO_TIMEOUT)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_type_i(cmd_type_i),
    .cmd_chan_i(cmd_chan_i),
    .cmd_word_i(cmd_word_i),
    .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o),
    .tx_done_tick_i(tx_done_tick_i),
`ifdef UART_CMD_ECHO_CHECK_EN
    .rx_done_tick_i(rx_done_tick_i),
    .rx_data_i(rx_data_i),
`endif
    .cmd_done_o(cmd_done_o),
    .cmd_err_o(cmd_err_o),
    .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int starts = 0;
  int dones = 0;
  int errs = 0;
  int cyc = 0;
  int last_tick_cyc = 0;
  int uart_cnt = 0;
  int uart_no = 0;
  logic [7:0] uart_byte = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference byte sequences, written directly from the protocol definition
  task automatic push_exp(input logic [2:0] t, input logic [7:0] ch, input logic [31:0] w);
    case (t)
      3'd0: begin
        exp_q.push_back(CMD_DATA);
        exp_q.push_back(ch);
        for (int i = 0; i < PACK_NUM; i++) exp_q.push_back(w[8*i +: 8]);
      end
      3'd1: begin
        exp_q.push_back(CMD_CTRL);
        exp_q.push_back(ch);
        exp_q.push_back({4'h0, w[3:0]});
      end
      3'd2: begin
        exp_q.push_back(CMD_FREQ);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
      end
      3'd3: begin
        exp_q.push_back(CMD_PERIOD);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
      end
      3'd4: begin
        exp_q.push_back(CMD_REPEAT);
        exp_q.push_back(ch);
        exp_q.push_back(w[7:0]);
      end
      3'd5: begin
        exp_q.push_back(CMD_GLOBAL);
        exp_q.push_back({7'h0, w[0]});
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Output monitor: scoreboard pop on each tx_start, pulse counting
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      if (tx_start_o) begin
        starts++;
        check("tx_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("tx_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
      end
      if (cmd_done_o) dones++;
      if (cmd_err_o) errs++;
    end
  end

  // UART TX model (and loopback echo when enabled)
  initial forever begin
    @(posedge clk);
    #1;
    tx_done_tick_i = 1'b0;
`ifdef UART_CMD_ECHO_CHECK_EN
    rx_done_tick_i = 1'b0;
    if (echo_pend && !rst_n) begin
      echo_pend = 1'b0;
      if (!echo_mute) begin
        rx_done_tick_i = 1'b1;
        rx_data_i = uart_byte ^ ((uart_no == corrupt_no) ? 8'h5A : 8'h00);
      end
    end
    if (rst_n) echo_pend = 1'b0;
`endif
    if (rst_n) begin
      uart_cnt = 0;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        tx_done_tick_i = 1'b1;
        last_tick_cyc = cyc;
        check("tx_hold", 32'(tx_data_o), 32'(uart_byte));
`ifdef UART_CMD_ECHO_CHECK_EN
        echo_pend = 1'b1;
`endif
      end
    end
    if (!rst_n && tx_start_o) begin
      uart_cnt = UART_CYC;
      uart_byte = tx_data_o;
      uart_no = starts + 1;
    end
  end

  task automatic issue(input logic [2:0] t, input logic [7:0] ch, input logic [31:0] w,
                       input bit keep);
    int n;
    n = 0;
    cmd_type_i = t;
    cmd_chan_i = ch;
    cmd_word_i = w;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_wait", 32'(cmd_ready_o), 1);
    push_exp(t, ch, w);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || !cmd_ready_o) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_wait", 32'(busy_o), 0);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  int s0, d0, e0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready_o), 1);
    check("rst_start", 32'(tx_start_o), 0);
    check("rst_data", 32'(tx_data_o), 0);
    check("rst_done", 32'(cmd_done_o), 0);
    check("rst_err", 32'(cmd_err_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // FREQ: latency of the first byte, byte count and single done pulse
    s0 = starts; d0 = dones;
    issue(3'd2, 8'h00, 32'h5555_5555, 1'b0);
    check("freq_busy", 32'(busy_o), 1);
    check("freq_ready_low", 32'(cmd_ready_o), 0);
    @(posedge clk);
    #1;
    check("freq_start_cycle2", 32'(tx_start_o), 1);
    wait_idle();
    check("freq_nstarts", 32'(starts - s0), 5);
    check("freq_ndone", 32'(dones - d0), 1);

    issue(3'd3, 8'h00, 32'h0000_0514, 1'b0);
    wait_idle();
    issue(3'd4, 8'd15, 32'h0000_0003, 1'b0);
    wait_idle();
    issue(3'd1, 8'd13, 32'h0000_0009, 1'b0);
    wait_idle();
    issue(3'd5, 8'h00, 32'h0000_0001, 1'b0);
    wait_idle();

    // Inputs scrambled right after acceptance must not affect the bytes
    s0 = starts;
    issue(3'd0, 8'h07, 32'h4433_2211, 1'b0);
    cmd_word_i = 32'hDEAD_BEEF;
    cmd_chan_i = 8'hAA;
    cmd_type_i = 3'd2;
    wait_idle();
    check("data_nstarts", 32'(starts - s0), 2 + PACK_NUM);

    // Illegal type
    s0 = starts; e0 = errs;
    issue(3'd7, 8'h01, 32'h1234_5678, 1'b0);
    check("illegal_err_pulse", 32'(cmd_err_o), 1);
    @(posedge clk);
    #1;
    check("illegal_ready_back", 32'(cmd_ready_o), 1);
    check("illegal_err_clear", 32'(cmd_err_o), 0);
    check("illegal_nstarts", 32'(starts - s0), 0);
    check("illegal_nerr", 32'(errs - e0), 1);

    // cmd_valid_i held high: the second command waits for cmd_done_o
    issue(3'd0, 8'h03, 32'h0A0B_0C0D, 1'b1);
    cmd_type_i = 3'd4;
    cmd_chan_i = 8'h21;
    cmd_word_i = 32'h0000_0077;
    push_exp(3'd4, 8'h21, 32'h0000_0077);
    n = 0;
    while (!cmd_done_o && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_done", 32'(cmd_done_o), 1);
    check("held_ready_in_fin", 32'(cmd_ready_o), 0);
    @(posedge clk);
    #1;
    check("held_ready_after_done", 32'(cmd_ready_o), 1);
    @(posedge clk);
    #1;
    check("held_second_busy", 32'(busy_o), 1);
    cmd_valid_i = 1'b0;
    wait_idle();

    // Reset during the third byte of a DATA command
    s0 = starts;
    issue(3'd0, 8'h05, 32'hCAFE_F00D, 1'b0);
    n = 0;
    while (starts - s0 < 3 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_byte3", 32'(starts - s0), 3);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_mid_ready", 32'(cmd_ready_o), 1);
    check("rst_mid_start", 32'(tx_start_o), 0);
    check("rst_mid_data", 32'(tx_data_o), 0);
    check("rst_mid_done", 32'(cmd_done_o), 0);
    check("rst_mid_err", 32'(cmd_err_o), 0);
    check("rst_mid_busy", 32'(busy_o), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    s0 = starts; d0 = dones;
    issue(3'd0, 8'h09, 32'h8877_6655, 1'b0);
    wait_idle();
    check("post_rst_nstarts", 32'(starts - s0), 2 + PACK_NUM);
    check("post_rst_ndone", 32'(dones - d0), 1);

`ifdef UART_CMD_ECHO_CHECK_EN
    // Corrupted echo of the second byte aborts the command
    s0 = starts; d0 = dones; e0 = errs;
    corrupt_no = starts + 2;
    issue(3'd4, 8'h02, 32'h0000_0044, 1'b0);
    void'(exp_q.pop_back());
    wait_idle();
    corrupt_no = 0;
    check("echo_bad_nstarts", 32'(starts - s0), 2);
    check("echo_bad_nerr", 32'(errs - e0), 1);
    check("echo_bad_ndone", 32'(dones - d0), 0);

    // Missing echo: error exactly ECHO_TIMEOUT cycles after the done tick
    s0 = starts;
    echo_mute = 1'b1;
    issue(3'd5, 8'h00, 32'h0000_0001, 1'b0);
    void'(exp_q.pop_back());
    n = 0;
    while (!cmd_err_o && n < ECHO_TIMEOUT + 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("echo_to_err", 32'(cmd_err_o), 1);
    check("echo_to_latency", 32'(cyc - last_tick_cyc), ECHO_TIMEOUT);
    echo_mute = 1'b0;
    wait_idle();
    check("echo_to_nstarts", 32'(starts - s0), 1);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
